// File: rtl/rf_wb_arbiter_if.sv
// Writeback request / regfile write bus between execute units and rf_wb_arbiter.
// slave = arbiter view, master = requester/regfile side.
interface rf_wb_arbiter_if #(
    parameter int unsigned ENTRY_WIDTH = 32,
    parameter int unsigned N_ENTRIES   = 32,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned N_WR_PORTS  = 2
);
    localparam int unsigned PTR_WIDTH = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    logic [N_REQ-1:0]                        req_valid;
    logic [N_REQ-1:0][PTR_WIDTH-1:0]         req_addr;
    logic [N_REQ-1:0][ENTRY_WIDTH-1:0]       req_data;
    logic [N_REQ-1:0]                        req_ready;
    logic [N_WR_PORTS-1:0]                   wr_en;
    logic [N_WR_PORTS-1:0][PTR_WIDTH-1:0]    wr_addr;
    logic [N_WR_PORTS-1:0][ENTRY_WIDTH-1:0]  wr_data;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter of N_REQ writeback requesters onto N_WR_PORTS registered regfile write ports.
// Optional RF_WB_X0_DROP_EN: writes to register 0 are accepted and discarded without using a port.
module rf_wb_arbiter #(
    parameter int unsigned ENTRY_WIDTH = 32,
    parameter int unsigned N_ENTRIES   = 32,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned N_WR_PORTS  = 2
) (
    input  logic           clk,
    input  logic           rst_aL,
    rf_wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_WIDTH = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int unsigned RR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [RR_W-1:0]                        r_rr_ptr;
    logic [N_WR_PORTS-1:0]                  r_wr_en;
    logic [N_WR_PORTS-1:0][PTR_WIDTH-1:0]   r_wr_addr;
    logic [N_WR_PORTS-1:0][ENTRY_WIDTH-1:0] r_wr_data;

    logic [RR_W-1:0]                        w_rr_next;
    logic [N_REQ-1:0]                       w_ready;
    logic [N_WR_PORTS-1:0]                  w_port_en;
    logic [N_WR_PORTS-1:0][PTR_WIDTH-1:0]   w_port_addr;
    logic [N_WR_PORTS-1:0][ENTRY_WIDTH-1:0] w_port_data;

    // Scan from rr_ptr; the k-th accepted requester fills port k, same-address requesters wait.
    always_comb begin
        logic [RR_W-1:0] w_idx;
        int unsigned     w_n_pick;
        logic            w_conflict;
        logic            w_x0;

        w_rr_next   = r_rr_ptr;
        w_ready     = '0;
        w_port_en   = '0;
        w_port_addr = '0;
        w_port_data = '0;
        w_n_pick    = 0;
        w_idx       = '0;
        w_conflict  = 1'b0;
        w_x0        = 1'b0;

        for (int unsigned j = 0; j < N_REQ; j++) begin
            w_idx      = RR_W'((32'(r_rr_ptr) + j) % N_REQ);
            w_conflict = 1'b0;
            for (int unsigned k = 0; k < N_WR_PORTS; k++) begin
                if (k < w_n_pick && w_port_addr[k] == bus.req_addr[w_idx])
                    w_conflict = 1'b1;
            end
`ifdef RF_WB_X0_DROP_EN
            w_x0 = (bus.req_addr[w_idx] == '0);
`else
            w_x0 = 1'b0;
`endif
            if (bus.req_valid[w_idx]) begin
                if (w_x0) begin
                    w_ready[w_idx] = 1'b1;
                end else if (w_n_pick < N_WR_PORTS && !w_conflict) begin
                    w_ready[w_idx] = 1'b1;
                    for (int unsigned k = 0; k < N_WR_PORTS; k++) begin
                        if (k == w_n_pick) begin
                            w_port_en[k]   = 1'b1;
                            w_port_addr[k] = bus.req_addr[w_idx];
                            w_port_data[k] = bus.req_data[w_idx];
                        end
                    end
                    w_n_pick  = w_n_pick + 1;
                    w_rr_next = RR_W'((32'(w_idx) + 1) % N_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_rr_ptr  <= '0;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_port_en;
            for (int unsigned k = 0; k < N_WR_PORTS; k++) begin
                if (w_port_en[k]) begin
                    r_wr_addr[k] <= w_port_addr[k];
                    r_wr_data[k] <= w_port_data[k];
                end
            end
            if (|w_port_en)
                r_rr_ptr <= w_rr_next;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed cases plus randomized traffic against a queue-based model.
module tb_rf_wb_arbiter;
    localparam int unsigned EW = 32;
    localparam int unsigned NE = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 5;

    logic clk    = 1'b0;
    logic rst_aL = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.ENTRY_WIDTH(EW), .N_ENTRIES(NE), .N_REQ(NR), .N_WR_PORTS(NP)) bus ();

    rf_wb_arbiter #(.ENTRY_WIDTH(EW), .N_ENTRIES(NE), .N_REQ(NR), .N_WR_PORTS(NP)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model state: rr pointer, picks of the current cycle, expected write-port contents
    int              m_rr;
    int              picks[$];
    logic [NR-1:0]   m_ready;
    logic [NP-1:0]   m_en;
    logic [AW-1:0]   m_addr[NP];
    logic [EW-1:0]   m_data[NP];
    bit              pend[NR];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_rr = 0;
        m_en = '0;
        for (int k = 0; k < NP; k++) begin
            m_addr[k] = '0;
            m_data[k] = '0;
        end
    endfunction

    function automatic void model_grant();
        m_ready = '0;
        picks.delete();
        for (int j = 0; j < NR; j++) begin
            int i;
            bit hit;
            i   = (m_rr + j) % NR;
            hit = 1'b0;
            if (!bus.req_valid[i]) continue;
`ifdef RF_WB_X0_DROP_EN
            if (bus.req_addr[i] == 0) begin
                m_ready[i] = 1'b1;
                continue;
            end
`endif
            foreach (picks[p]) if (bus.req_addr[picks[p]] == bus.req_addr[i]) hit = 1'b1;
            if (picks.size() < NP && !hit) begin
                picks.push_back(i);
                m_ready[i] = 1'b1;
            end
        end
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < NP; k++) begin
            if (k < picks.size()) begin
                m_en[k]   = 1'b1;
                m_addr[k] = bus.req_addr[picks[k]];
                m_data[k] = bus.req_data[picks[k]];
            end else begin
                m_en[k] = 1'b0;
            end
        end
        if (picks.size() > 0) m_rr = (picks[$] + 1) % NR;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".wr_en"}, bus.wr_en, m_en);
        for (int k = 0; k < NP; k++) begin
            check($sformatf("%s.wr_addr%0d", tag, k), bus.wr_addr[k], m_addr[k]);
            check($sformatf("%s.wr_data%0d", tag, k), bus.wr_data[k], m_data[k]);
        end
    endtask

    // Inputs are driven just after a rising edge; ready is checked before the next edge, outputs just after it.
    task automatic step(input string tag);
        #1;
        model_grant();
        check({tag, ".ready"}, bus.req_ready, m_ready);
        @(posedge clk);
        if (rst_aL) model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [EW-1:0] d);
        bus.req_valid[i] = v;
        bus.req_addr[i]  = a;
        bus.req_data[i]  = d;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        model_reset();

        // Reset held with random requests: outputs clear, ready follows rr_ptr=0
        repeat (3) begin
            for (int i = 0; i < NR; i++)
                set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
            step("reset");
        end
        bus.req_valid = '0;
        rst_aL = 1'b1;

        // Full load
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), $urandom);
        #1 check("full.ready0", bus.req_ready, 4'b0011);
        step("full0");
        check("full.en0", bus.wr_en, 2'b11);
        check("full.p0addr", bus.wr_addr[0], 1);
        check("full.p1addr", bus.wr_addr[1], 2);
        bus.req_valid = 4'b1100;
        #1 check("full.ready1", bus.req_ready, 4'b1100);
        step("full1");
        check("full.p0addr2", bus.wr_addr[0], 3);
        check("full.p1addr2", bus.wr_addr[1], 4);
        bus.req_valid = '0;

        // Same-address conflict
        set_req(0, 1'b1, 5, 32'hA);
        set_req(1, 1'b1, 5, 32'hB);
        #1 check("conf.ready0", bus.req_ready, 4'b0001);
        step("conf0");
        check("conf.en0", bus.wr_en, 2'b01);
        check("conf.dataA", bus.wr_data[0], 32'hA);
        bus.req_valid = 4'b0010;
        #1 check("conf.ready1", bus.req_ready, 4'b0010);
        step("conf1");
        check("conf.en1", bus.wr_en, 2'b01);
        check("conf.dataB", bus.wr_data[0], 32'hB);
        bus.req_valid = '0;

        // Wrap to the last requester
        set_req(3, 1'b1, 7, 32'hDEAD);
        #1 check("wrap.ready", bus.req_ready, 4'b1000);
        step("wrap");
        check("wrap.en", bus.wr_en, 2'b01);
        check("wrap.addr", bus.wr_addr[0], 7);
        check("wrap.data", bus.wr_data[0], 32'hDEAD);
        bus.req_valid = '0;
        step("idle");

        // Register-0 destination
        set_req(0, 1'b1, 3, $urandom);
        set_req(1, 1'b1, 0, $urandom);
        set_req(2, 1'b1, 4, $urandom);
`ifdef RF_WB_X0_DROP_EN
        #1 check("x0.ready", bus.req_ready, 4'b0111);
        step("x0");
        check("x0.en", bus.wr_en, 2'b11);
        check("x0.p0addr", bus.wr_addr[0], 3);
        check("x0.p1addr", bus.wr_addr[1], 4);
        bus.req_valid = '0;
        step("x0.drain");
`else
        #1 check("x0.ready", bus.req_ready, 4'b0011);
        step("x0");
        check("x0.en", bus.wr_en, 2'b11);
        check("x0.p0addr", bus.wr_addr[0], 3);
        check("x0.p1addr", bus.wr_addr[1], 0);
        bus.req_valid = 4'b0100;
        step("x0.drain");
        bus.req_valid = '0;
`endif

        // Asynchronous reset between edges while writes are registered
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 9), $urandom);
        step("areset.load");
        check("areset.en_before", bus.wr_en, 2'b11);
        bus.req_valid = '0;
        #2 rst_aL = 1'b0;
        #1;
        model_reset();
        check_outputs("areset.async");
        #2 rst_aL = 1'b1;
        step("areset.after");
        step("areset.after2");

        // Randomized traffic honouring the hold-until-ready rule
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        repeat (400) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    set_req(i, 1'b1, AW'($urandom_range(0, 7)), $urandom);
                end
                bus.req_valid[i] = pend[i];
            end
            step("rand");
            for (int i = 0; i < NR; i++) if (m_ready[i]) pend[i] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
